// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
//   Stall/flush sequencer for a 5-stage pipeline (IF/ID, ID/EX, EX/MEM, MEM/WB).
//   Detects load-use hazards and taken-branch redirects, runs the dmem
//   request/acknowledge handshake, and freezes the pipeline while memory is busy.
//   Stage registers act on the enables/flushes at the next rising clk edge.
//
//   Build option: define PIPE_PERF_CNT_EN to add saturating performance counters.
//
// Ports
//   clk, reset              clock (rising edge), asynchronous active-high reset
//   id_rs1/rs2_addr, id_uses_rs1/rs2   source operands of the ID instruction
//   ex_MemRead, ex_RegWrite, ex_rd_addr  EX instruction destination info
//   ex_branch_taken         EX resolved a taken branch/jump
//   mem_MemRead/MemWrite    memory op in MEM; dmem_ack completes it this cycle
//   dmem_req                data memory request
//   pc_en, if_id_en, id_ex_en, ex_mem_en   stage load enables
//   if_id_flush, id_ex_flush               stage squash controls
//   mem_wb_bubble           MEM/WB loads RegWrite=0
//   mem_err                 sticky dmem timeout flag
//   perf_stall_cycles, perf_flushes, perf_load_use  (PIPE_PERF_CNT_EN only)

module pipe_hazard_ctrl #(
    parameter int MAX_WAIT = 16,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       id_rs1_addr,
    input  logic [4:0]       id_rs2_addr,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic             ex_MemRead,
    input  logic             ex_RegWrite,
    input  logic [4:0]       ex_rd_addr,
    input  logic             ex_branch_taken,
    input  logic             mem_MemRead,
    input  logic             mem_MemWrite,
    input  logic             dmem_ack,
    output logic             dmem_req,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             if_id_flush,
    output logic             id_ex_en,
    output logic             id_ex_flush,
    output logic             ex_mem_en,
    output logic             mem_wb_bubble,
`ifdef PIPE_PERF_CNT_EN
    output logic [CNT_W-1:0] perf_stall_cycles,
    output logic [CNT_W-1:0] perf_flushes,
    output logic [CNT_W-1:0] perf_load_use,
`endif
    output logic             mem_err
);

    localparam int WCW = $clog2(MAX_WAIT + 1);

    // Elaboration-time sanity checks on the parameters.
    if (MAX_WAIT < 2) begin : g_bad_max_wait
        $error("pipe_hazard_ctrl: MAX_WAIT must be >= 2");
    end
    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("pipe_hazard_ctrl: CNT_W must be >= 1");
    end

    typedef enum logic [1:0] {RUN, MEM_WAIT, ERROR} state_e;

    state_e           state_q, state_d;
    logic [WCW-1:0]   wait_cnt_q, wait_cnt_d;
    logic             mem_err_q, mem_err_d;

    logic mem_op;
    logic freeze;
    logic load_use;
    logic br_flush;   // branch redirect actually applied this cycle
    logic lu_stall;   // load-use bubble actually applied this cycle

    assign mem_op = mem_MemRead | mem_MemWrite;

    assign load_use = ex_MemRead & ex_RegWrite & (ex_rd_addr != 5'd0) &
                      ((id_uses_rs1 & (id_rs1_addr == ex_rd_addr)) |
                       (id_uses_rs2 & (id_rs2_addr == ex_rd_addr)));

    // ------------------------------------------------------------------
    // Memory handshake FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= RUN;
            wait_cnt_q <= '0;
            mem_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            mem_err_q  <= mem_err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        mem_err_d  = mem_err_q;
        freeze     = 1'b0;
        case (state_q)
            RUN: begin
                // An acked access in RUN is zero-wait and needs no freeze.
                if (mem_op && !dmem_ack) begin
                    freeze     = 1'b1;
                    state_d    = MEM_WAIT;
                    wait_cnt_d = WCW'(1);
                end
            end
            MEM_WAIT: begin
                if (dmem_ack) begin
                    // Released in the ack cycle itself.
                    state_d    = RUN;
                    wait_cnt_d = '0;
                end else begin
                    freeze     = 1'b1;
                    wait_cnt_d = wait_cnt_q + WCW'(1);
                    if (wait_cnt_q == WCW'(MAX_WAIT - 1)) begin
                        state_d   = ERROR;
                        mem_err_d = 1'b1;
                    end
                end
            end
            ERROR: begin
                freeze = 1'b1;   // only reset leaves this state
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Stage controls. Freeze outranks the branch so a held taken branch
    // fires on the first unfrozen cycle; the branch outranks load-use
    // because the stalled ID instruction is squashed anyway.
    // ------------------------------------------------------------------
    always_comb begin
        dmem_req      = mem_op & (state_q != ERROR);
        pc_en         = 1'b1;
        if_id_en      = 1'b1;
        if_id_flush   = 1'b0;
        id_ex_en      = 1'b1;
        id_ex_flush   = 1'b0;
        ex_mem_en     = 1'b1;
        mem_wb_bubble = 1'b0;
        mem_err       = mem_err_q;
        br_flush      = 1'b0;
        lu_stall      = 1'b0;

        if (freeze) begin
            pc_en         = 1'b0;
            if_id_en      = 1'b0;
            id_ex_en      = 1'b0;
            ex_mem_en     = 1'b0;
            mem_wb_bubble = 1'b1;
        end else if (ex_branch_taken) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            br_flush    = 1'b1;
        end else if (load_use) begin
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            id_ex_flush = 1'b1;
            lu_stall    = 1'b1;
        end

        // Outputs are forced low while reset is held, independent of clk.
        if (reset) begin
            dmem_req      = 1'b0;
            pc_en         = 1'b0;
            if_id_en      = 1'b0;
            if_id_flush   = 1'b0;
            id_ex_en      = 1'b0;
            id_ex_flush   = 1'b0;
            ex_mem_en     = 1'b0;
            mem_wb_bubble = 1'b0;
            mem_err       = 1'b0;
            br_flush      = 1'b0;
            lu_stall      = 1'b0;
        end
    end

`ifdef PIPE_PERF_CNT_EN
    // ------------------------------------------------------------------
    // Saturating performance counters
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q, lu_cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
            lu_cnt_q    <= '0;
        end else begin
            if ((freeze || lu_stall) && (stall_cnt_q != '1))
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            if (br_flush && (flush_cnt_q != '1))
                flush_cnt_q <= flush_cnt_q + CNT_W'(1);
            if (lu_stall && (lu_cnt_q != '1))
                lu_cnt_q <= lu_cnt_q + CNT_W'(1);
        end
    end

    assign perf_stall_cycles = stall_cnt_q;
    assign perf_flushes      = flush_cnt_q;
    assign perf_load_use     = lu_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl
//   Directed vectors for pipe_hazard_ctrl with MAX_WAIT=4. Inputs change
//   just after the falling edge; outputs are sampled 1 time unit later.
//   Output vector layout: {dmem_req, pc_en, if_id_en, if_id_flush,
//   id_ex_en, id_ex_flush, ex_mem_en, mem_wb_bubble, mem_err}.

module tb_pipe_hazard_ctrl;

    localparam int MAX_WAIT = 4;
    localparam int CNT_W    = 32;

    // Expected control vectors
    localparam logic [8:0] V_RST  = 9'b000000000;
    localparam logic [8:0] V_NORM = 9'b011010100;
    localparam logic [8:0] V_MEMN = 9'b111010100; // normal flow with dmem_req
    localparam logic [8:0] V_LU   = 9'b000011100;
    localparam logic [8:0] V_BR   = 9'b011111100;
    localparam logic [8:0] V_MEMB = 9'b111111100; // branch flush with dmem_req
    localparam logic [8:0] V_FRZ  = 9'b100000010;
    localparam logic [8:0] V_ERR  = 9'b000000011;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] id_rs1_addr, id_rs2_addr, ex_rd_addr;
    logic       id_uses_rs1, id_uses_rs2;
    logic       ex_MemRead, ex_RegWrite, ex_branch_taken;
    logic       mem_MemRead, mem_MemWrite, dmem_ack;
    logic       dmem_req, pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush;
    logic       ex_mem_en, mem_wb_bubble, mem_err;
`ifdef PIPE_PERF_CNT_EN
    logic [CNT_W-1:0] perf_stall_cycles, perf_flushes, perf_load_use;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    logic [8:0] outv;
    assign outv = {dmem_req, pc_en, if_id_en, if_id_flush, id_ex_en,
                   id_ex_flush, ex_mem_en, mem_wb_bubble, mem_err};

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)) dut (
        .clk             (clk),
        .reset           (reset),
        .id_rs1_addr     (id_rs1_addr),
        .id_rs2_addr     (id_rs2_addr),
        .id_uses_rs1     (id_uses_rs1),
        .id_uses_rs2     (id_uses_rs2),
        .ex_MemRead      (ex_MemRead),
        .ex_RegWrite     (ex_RegWrite),
        .ex_rd_addr      (ex_rd_addr),
        .ex_branch_taken (ex_branch_taken),
        .mem_MemRead     (mem_MemRead),
        .mem_MemWrite    (mem_MemWrite),
        .dmem_ack        (dmem_ack),
        .dmem_req        (dmem_req),
        .pc_en           (pc_en),
        .if_id_en        (if_id_en),
        .if_id_flush     (if_id_flush),
        .id_ex_en        (id_ex_en),
        .id_ex_flush     (id_ex_flush),
        .ex_mem_en       (ex_mem_en),
        .mem_wb_bubble   (mem_wb_bubble),
`ifdef PIPE_PERF_CNT_EN
        .perf_stall_cycles (perf_stall_cycles),
        .perf_flushes      (perf_flushes),
        .perf_load_use     (perf_load_use),
`endif
        .mem_err         (mem_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        id_rs1_addr = 5'd0; id_rs2_addr = 5'd0; ex_rd_addr = 5'd0;
        id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0;
        ex_MemRead = 1'b0; ex_RegWrite = 1'b0; ex_branch_taken = 1'b0;
        mem_MemRead = 1'b0; mem_MemWrite = 1'b0; dmem_ack = 1'b0;
    endtask

    // Load in EX writing rd, ID reading rs2 (and rs1 if given).
    task automatic set_lu(input logic [4:0] rd, input logic [4:0] rs1, input logic u1,
                          input logic [4:0] rs2, input logic u2);
        ex_MemRead = 1'b1; ex_RegWrite = 1'b1; ex_rd_addr = rd;
        id_rs1_addr = rs1; id_uses_rs1 = u1;
        id_rs2_addr = rs2; id_uses_rs2 = u2;
    endtask

    // Sample the current cycle's outputs, then move to the next falling edge.
    task automatic step(input string tag, input logic [8:0] exp);
        #1;
        chk(tag, 32'(outv), 32'(exp));
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        idle();
        reset = 1'b1;
        mem_MemRead = 1'b1;          // dmem_req must stay low while in reset
        ex_branch_taken = 1'b1;
        @(negedge clk);
        step("reset_outs", V_RST);
        idle();
        reset = 1'b0;

        // Normal flow
        step("norm0", V_NORM);
        step("norm1", V_NORM);

        // Load-use on rs2: exactly one bubble
        set_lu(5'd5, 5'd1, 1'b1, 5'd5, 1'b1);
        step("lu_rs2", V_LU);
        idle();
        step("lu_after", V_NORM);
        // rd = x0 never stalls
        set_lu(5'd0, 5'd0, 1'b1, 5'd0, 1'b1);
        step("lu_x0", V_NORM);
        // matching rs1 that is not used -> no stall
        set_lu(5'd7, 5'd7, 1'b0, 5'd3, 1'b1);
        step("lu_unused", V_NORM);
        // matching rs1 that is used -> stall
        set_lu(5'd7, 5'd7, 1'b1, 5'd3, 1'b1);
        step("lu_rs1", V_LU);
        idle();

        // Three-cycle memory wait with a taken branch held in EX
        mem_MemRead = 1'b1; ex_branch_taken = 1'b1;
        step("wait1", V_FRZ);
        step("wait2", V_FRZ);
        step("wait3", V_FRZ);
        dmem_ack = 1'b1;
        step("wait_ack", V_MEMB);   // release + deferred branch flush
        idle();
        step("wait_done", V_NORM);

        // Branch together with a matching load-use: branch wins
        set_lu(5'd9, 5'd9, 1'b1, 5'd0, 1'b0);
        ex_branch_taken = 1'b1;
        step("br_lu", V_BR);
        idle();

        // Zero-wait store
        mem_MemWrite = 1'b1; dmem_ack = 1'b1;
        step("zero_wait", V_MEMN);
        idle();
        step("zero_wait_done", V_NORM);

        // Timeout: 4 frozen cycles, then ERROR
        mem_MemWrite = 1'b1;
        step("to1", V_FRZ);
        step("to2", V_FRZ);
        step("to3", V_FRZ);
        step("to4", V_FRZ);
        step("err", V_ERR);
        dmem_ack = 1'b1;               // ack cannot revive ERROR
        step("err_sticky", V_ERR);
        idle();
        step("err_idle", V_ERR);

        // Reset out of ERROR
        do_reset();
        step("post_err_rst", V_NORM);

        // Asynchronous reset mid-wait
        mem_MemRead = 1'b1;
        step("mw1", V_FRZ);
        step("mw2", V_FRZ);
        #2 reset = 1'b1;
        #1 chk("async_rst", 32'(outv), 32'(V_RST));
        @(negedge clk);
        reset = 1'b0;
        idle();
        step("post_async_rst", V_NORM);

`ifdef PIPE_PERF_CNT_EN
        do_reset();
        #1 chk("perf_rst", perf_stall_cycles, 32'd0);
        mem_MemRead = 1'b1;
        step("p_w1", V_FRZ);
        step("p_w2", V_FRZ);
        step("p_w3", V_FRZ);
        dmem_ack = 1'b1;
        step("p_ack", V_MEMN);
        idle();
        set_lu(5'd4, 5'd4, 1'b1, 5'd0, 1'b0);
        step("p_lu", V_LU);
        idle();
        ex_branch_taken = 1'b1;
        step("p_br1", V_BR);
        step("p_br2", V_BR);
        idle();
        #1;
        chk("perf_stall", perf_stall_cycles, 32'd4);
        chk("perf_lu", perf_load_use, 32'd1);
        chk("perf_flush", perf_flushes, 32'd2);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    // Hard stop if the sequence ever stalls
    initial begin
        #20000;
        $display("FAIL timeout: simulation did not finish, want finish before 20000");
        $fatal(1, "timeout");
    end

endmodule
